// File: rtl/traffic_light_monitor.sv
// Purpose: passive checker for a red/yellow/green lamp bus; times each phase and full cycle, flags misbehaviour.
// Latency: reports and flags are registered at the edge that first samples the new lamp pattern (visible 1 cycle later).
// Backpressure: none; pure observer, dur_valid/cycle_valid are single-cycle pulses with no ready.
module traffic_light_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               red,
  input  logic               yellow,
  input  logic               green,
  input  logic               clr_err,
  output logic               in_sync,
  output logic [1:0]         phase,
  output logic               dur_valid,
  output logic [1:0]         dur_phase,
  output logic [CNT_W-1:0]   dur_cycles,
  output logic               cycle_valid,
  output logic [CNT_W+1:0]   cycle_len,
  output logic               err_illegal,
  output logic               err_seq,
  output logic               err_timeout
);

  localparam logic [1:0] PH_R  = 2'd0;
  localparam logic [1:0] PH_RY = 2'd1;
  localparam logic [1:0] PH_G  = 2'd2;
  localparam logic [1:0] PH_Y  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LIM = TIMEOUT[CNT_W-1:0];

  typedef enum logic {SYNC, TRACK} state_t;

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [1:0]       held_q, held_d;
  logic             held_vld_q, held_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W+1:0] acc_q, acc_d;
  logic             started_q, started_d;
  logic             dur_valid_d;
  logic [1:0]       dur_phase_d;
  logic [CNT_W-1:0] dur_cycles_d;
  logic             cycle_valid_d;
  logic [CNT_W+1:0] cycle_len_d;
  logic             err_illegal_d, err_seq_d, err_timeout_d;

  logic             lamp_ok;
  logic [1:0]       lamp_ph;
  logic             trans_ok;
  logic             drop;
  logic             new_ill, new_seq, new_to;
  logic [CNT_W+1:0] acc_sum;

  assign in_sync = (state_q == TRACK);
  assign phase   = phase_q;

  // Decode the lamp pattern and judge whether a change is a legal successor.
  always_comb begin
    lamp_ok = 1'b1;
    lamp_ph = PH_R;
    case ({red, yellow, green})
      3'b100:  lamp_ph = PH_R;
      3'b110:  lamp_ph = PH_RY;
      3'b001:  lamp_ph = PH_G;
      3'b010:  lamp_ph = PH_Y;
      default: lamp_ok = 1'b0;
    endcase
    trans_ok = ((phase_q == PH_R)  && ((lamp_ph == PH_RY) || (lamp_ph == PH_G))) ||
               ((phase_q == PH_RY) && (lamp_ph == PH_G)) ||
               ((phase_q == PH_G)  && (lamp_ph == PH_Y)) ||
               ((phase_q == PH_Y)  && (lamp_ph == PH_R));
  end

  // Next-state, report and error logic for the SYNC/TRACK tracker.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    held_d        = held_q;
    held_vld_d    = held_vld_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    started_d     = started_q;
    dur_valid_d   = 1'b0;
    dur_phase_d   = dur_phase;
    dur_cycles_d  = dur_cycles;
    cycle_valid_d = 1'b0;
    cycle_len_d   = cycle_len;
    drop          = 1'b0;
    new_ill       = 1'b0;
    new_seq       = 1'b0;
    new_to        = 1'b0;
    acc_sum       = acc_q + {2'b00, cnt_q};

    case (state_q)
      SYNC: begin
        if (!lamp_ok) begin
          new_ill = 1'b1;
        end else if (!held_vld_q || (lamp_ph == held_q)) begin
          // First legal sample after reset only seeds the held phase.
          held_d     = lamp_ph;
          held_vld_d = 1'b1;
        end else begin
          state_d   = TRACK;
          phase_d   = lamp_ph;
          cnt_d     = CNT_ONE;
          acc_d     = '0;
          started_d = (lamp_ph == PH_R);
        end
      end
      default: begin
        if (!lamp_ok) begin
          new_ill = 1'b1;
          drop    = 1'b1;
          held_d  = phase_q;
        end else if (lamp_ph == phase_q) begin
          if (cnt_q < CNT_LIM) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            new_to = 1'b1;
            drop   = 1'b1;
            held_d = lamp_ph;
          end
        end else if (trans_ok) begin
          dur_valid_d  = 1'b1;
          dur_phase_d  = phase_q;
          dur_cycles_d = cnt_q;
          if (phase_q == PH_Y) begin
            // Only a cycle that began on a real R entry is complete.
            if (started_q) begin
              cycle_valid_d = 1'b1;
              cycle_len_d   = acc_sum;
            end
            acc_d     = '0;
            started_d = 1'b1;
          end else begin
            acc_d = acc_sum;
          end
          phase_d = lamp_ph;
          cnt_d   = CNT_ONE;
        end else begin
          new_seq = 1'b1;
          drop    = 1'b1;
          held_d  = lamp_ph;
        end
      end
    endcase

    if (drop) begin
      state_d    = SYNC;
      acc_d      = '0;
      started_d  = 1'b0;
      held_vld_d = 1'b1;
    end

    // A fresh error wins over a simultaneous clear.
    err_illegal_d = (err_illegal & ~clr_err) | new_ill;
    err_seq_d     = (err_seq     & ~clr_err) | new_seq;
    err_timeout_d = (err_timeout & ~clr_err) | new_to;
  end

  // State and output registers; async active-low reset zeros everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SYNC;
      phase_q     <= PH_R;
      held_q      <= PH_R;
      held_vld_q  <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      started_q   <= 1'b0;
      dur_valid   <= 1'b0;
      dur_phase   <= 2'd0;
      dur_cycles  <= '0;
      cycle_valid <= 1'b0;
      cycle_len   <= '0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      held_q      <= held_d;
      held_vld_q  <= held_vld_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      started_q   <= started_d;
      dur_valid   <= dur_valid_d;
      dur_phase   <= dur_phase_d;
      dur_cycles  <= dur_cycles_d;
      cycle_valid <= cycle_valid_d;
      cycle_len   <= cycle_len_d;
      err_illegal <= err_illegal_d;
      err_seq     <= err_seq_d;
      err_timeout <= err_timeout_d;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Purpose: randomized and directed bench for traffic_light_monitor against a behavioural model.
// Latency: expects every report/flag one cycle after the lamp sample that causes it.
// Backpressure: none; the DUT is a passive observer.
module tb_traffic_light_monitor;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 200;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             red, yellow, green, clr_err;
  logic             in_sync;
  logic [1:0]       phase;
  logic             dur_valid;
  logic [1:0]       dur_phase;
  logic [CNT_W-1:0] dur_cycles;
  logic             cycle_valid;
  logic [CNT_W+1:0] cycle_len;
  logic             err_illegal, err_seq, err_timeout;

  traffic_light_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .red(red), .yellow(yellow), .green(green),
    .clr_err(clr_err), .in_sync(in_sync), .phase(phase), .dur_valid(dur_valid),
    .dur_phase(dur_phase), .dur_cycles(dur_cycles), .cycle_valid(cycle_valid),
    .cycle_len(cycle_len), .err_illegal(err_illegal), .err_seq(err_seq),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] pcode [4];
  logic [2:0] icode [4];

  // Behavioural model: plain integers, phase history as a queue of durations.
  int m_sync, m_phase, m_run, m_held, m_started;
  int m_ill, m_seq, m_to;
  int e_dv, e_dp, e_dc, e_cv, e_cl;
  int cyc_q[$];

  // Observed reports, for spec-literal checks on directed sequences.
  int obs_rep[$];
  int obs_cyc[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dec(input logic [2:0] c);
    case (c)
      3'b100:  return 0;
      3'b110:  return 1;
      3'b001:  return 2;
      3'b010:  return 3;
      default: return -1;
    endcase
  endfunction

  function automatic bit succ_ok(input int a, input int b);
    case (a)
      0:       return (b == 1) || (b == 2);
      1:       return b == 2;
      2:       return b == 3;
      default: return b == 0;
    endcase
  endfunction

  task automatic model_reset();
    m_sync = 0; m_phase = 0; m_run = 0; m_held = -1; m_started = 0;
    m_ill = 0; m_seq = 0; m_to = 0;
    e_dv = 0; e_dp = 0; e_dc = 0; e_cv = 0; e_cl = 0;
    cyc_q.delete();
  endtask

  task automatic lose_sync(input int hold);
    m_sync = 0; m_held = hold; m_started = 0;
    cyc_q.delete();
  endtask

  task automatic model_step(input int p, input bit clr);
    int ni, ns, nt, sum;
    ni = 0; ns = 0; nt = 0;
    e_dv = 0; e_cv = 0;
    if (m_sync == 0) begin
      if (p < 0) ni = 1;
      else if (m_held < 0 || p == m_held) m_held = p;
      else begin
        m_sync = 1; m_phase = p; m_run = 1;
        cyc_q.delete(); m_started = (p == 0);
      end
    end else if (p < 0) begin
      ni = 1; lose_sync(m_phase);
    end else if (p == m_phase) begin
      if (m_run < TIMEOUT) m_run++;
      else begin nt = 1; lose_sync(p); end
    end else if (succ_ok(m_phase, p)) begin
      e_dv = 1; e_dp = m_phase; e_dc = m_run;
      cyc_q.push_back(m_run);
      if (m_phase == 3) begin
        if (m_started != 0) begin
          sum = 0;
          foreach (cyc_q[i]) sum += cyc_q[i];
          e_cv = 1; e_cl = sum;
        end
        cyc_q.delete(); m_started = 1;
      end
      m_phase = p; m_run = 1;
    end else begin
      ns = 1; lose_sync(p);
    end
    m_ill = ((m_ill != 0) && !clr) || (ni != 0);
    m_seq = ((m_seq != 0) && !clr) || (ns != 0);
    m_to  = ((m_to  != 0) && !clr) || (nt != 0);
  endtask

  // Drive one lamp sample, advance one edge, then compare against the model.
  task automatic step(input logic [2:0] c, input bit clr);
    {red, yellow, green} = c;
    clr_err = clr;
    model_step(dec(c), clr);
    @(posedge clk);
    #1;
    check("in_sync", int'(in_sync), m_sync);
    check("phase", int'(phase), m_phase);
    check("dur_valid", int'(dur_valid), e_dv);
    check("cycle_valid", int'(cycle_valid), e_cv);
    check("err_illegal", int'(err_illegal), m_ill);
    check("err_seq", int'(err_seq), m_seq);
    check("err_timeout", int'(err_timeout), m_to);
    if (e_dv != 0) begin
      check("dur_phase", int'(dur_phase), e_dp);
      check("dur_cycles", int'(dur_cycles), e_dc);
    end
    if (e_cv != 0) check("cycle_len", int'(cycle_len), e_cl);
    if (dur_valid) obs_rep.push_back(int'(dur_phase) * 1000 + int'(dur_cycles));
    if (cycle_valid) obs_cyc.push_back(int'(cycle_len));
    clr_err = 1'b0;
  endtask

  task automatic run(input int p, input int len);
    for (int k = 0; k < len; k++) step(pcode[p], 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_sync"}, int'(in_sync), 0);
    check({tag, "_phase"}, int'(phase), 0);
    check({tag, "_dur_valid"}, int'(dur_valid), 0);
    check({tag, "_dur_phase"}, int'(dur_phase), 0);
    check({tag, "_dur_cycles"}, int'(dur_cycles), 0);
    check({tag, "_cycle_valid"}, int'(cycle_valid), 0);
    check({tag, "_cycle_len"}, int'(cycle_len), 0);
    check({tag, "_err_illegal"}, int'(err_illegal), 0);
    check({tag, "_err_seq"}, int'(err_seq), 0);
    check({tag, "_err_timeout"}, int'(err_timeout), 0);
  endtask

  // Asynchronous reset pulse in the middle of a cycle.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    #12;
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_rep [7];
    exp_rep = '{1006, 2016, 3006, 15, 1006, 2016, 3006};
    pcode = '{3'b100, 3'b110, 3'b001, 3'b010};
    icode = '{3'b000, 3'b011, 3'b101, 3'b111};
    rst_n = 1'b0; red = 1'b0; yellow = 1'b0; green = 1'b0; clr_err = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // 1: two full cycles, one cycle_valid of 43.
    obs_rep.delete(); obs_cyc.delete();
    for (int c = 0; c < 2; c++) begin
      run(0, 15); run(1, 6); run(2, 16); run(3, 6);
    end
    run(0, 1);
    check("t1_reports", obs_rep.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < obs_rep.size()) check("t1_report", obs_rep[i], exp_rep[i]);
    check("t1_cycles", obs_cyc.size(), 1);
    if (obs_cyc.size() > 0) check("t1_cycle_len", obs_cyc[0], 43);
    check("t1_in_sync", int'(in_sync), 1);

    // 2: one illegal sample while in G.
    run(1, 3); run(2, 5);
    obs_rep.delete();
    step(3'b101, 1'b0);
    check("t2_err_illegal", int'(err_illegal), 1);
    check("t2_in_sync", int'(in_sync), 0);
    run(2, 3);
    check("t2_no_report", obs_rep.size(), 0);
    step(pcode[2], 1'b1);
    check("t2_cleared", int'(err_illegal), 0);

    // 3: G followed by R is an illegal order.
    run(3, 4); run(0, 5); run(1, 3); run(2, 8);
    step(pcode[0], 1'b0);
    check("t3_err_seq", int'(err_seq), 1);
    check("t3_in_sync", int'(in_sync), 0);
    check("t3_no_dur", int'(dur_valid), 0);
    run(0, 2);
    step(pcode[1], 1'b0);
    check("t3_retrack", int'(in_sync), 1);

    // 4: G for exactly TIMEOUT samples is legal; one more is not.
    step(pcode[1], 1'b1);
    run(2, 200);
    step(pcode[3], 1'b0);
    check("t4_dur_valid", int'(dur_valid), 1);
    check("t4_dur_phase", int'(dur_phase), 2);
    check("t4_dur_cycles", int'(dur_cycles), 200);
    check("t4_no_timeout", int'(err_timeout), 0);
    run(3, 2); run(0, 3); run(2, 201);
    check("t4_err_timeout", int'(err_timeout), 1);
    check("t4_in_sync", int'(in_sync), 0);

    // 5: reset mid-G, then G->Y re-enters tracking silently.
    run(3, 3); run(0, 3); run(2, 4);
    do_reset();
    run(2, 3);
    step(pcode[3], 1'b0);
    check("t5_in_sync", int'(in_sync), 1);
    check("t5_no_dur", int'(dur_valid), 0);

    // 6: new err_seq wins over simultaneous clear; err_illegal clears.
    step(3'b000, 1'b0);
    check("t6_pre_illegal", int'(err_illegal), 1);
    run(0, 2);
    step(pcode[3], 1'b1);
    check("t6_err_seq", int'(err_seq), 1);
    check("t6_err_illegal", int'(err_illegal), 0);

    // Randomized phase streams with occasional faults, clears and resets.
    begin
      int p, r, len;
      p = 0;
      for (int seg = 0; seg < 400; seg++) begin
        r = $urandom_range(0, 99);
        if (r < 5) begin
          step(icode[$urandom_range(0, 3)], ($urandom_range(0, 3) == 0));
          continue;
        end else if (r < 7) begin
          do_reset();
        end else if (r < 12) begin
          p = $urandom_range(0, 3);
        end else if (p == 0) begin
          p = ($urandom_range(0, 1) == 0) ? 1 : 2;
        end else begin
          p = (p + 1) % 4;
          if (p == 1) p = 2;
        end
        len = ($urandom_range(0, 99) < 3) ? $urandom_range(198, 202) : $urandom_range(1, 12);
        for (int k = 0; k < len; k++) step(pcode[p], ($urandom_range(0, 15) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Passive observer of a red/yellow/green lamp bus driven by a traffic light controller. Each cycle it decodes the lamp pattern into a phase and measures how many cycles each phase lasts. It reports each completed phase duration and the full-cycle length, and raises sticky flags for illegal lamp combinations, illegal phase order and stuck phases. It is used as an in-system checker and as a bench scoreboard front-end.

Parameters:
CNT_W, 8, width of the per-phase cycle counter and dur_cycles
TIMEOUT, 200, maximum legal consecutive samples of one phase; must be < 2**CNT_W

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset; asynchronous, active-low
red  in  1  red lamp
yellow  in  1  yellow lamp
green  in  1  green lamp
clr_err  in  1  synchronous clear of all sticky error flags
in_sync  out  1  1 = tracking a legal phase sequence
phase  out  2  current tracked phase: 0=R, 1=RY, 2=G, 3=Y
dur_valid  out  1  one-cycle pulse; a completed phase duration is reported
dur_phase  out  2  phase code of the completed phase
dur_cycles  out  CNT_W  samples the completed phase lasted
cycle_valid  out  1  one-cycle pulse; a full R..Y cycle completed
cycle_len  out  CNT_W+2  total samples of the completed cycle
err_illegal  out  1  sticky; illegal lamp combination seen
err_seq  out  1  sticky; illegal phase transition seen
err_timeout  out  1  sticky; a phase exceeded TIMEOUT samples

Behaviour:
- Reset (async): all outputs 0. Internal state is SYNC, the counter is 0, and the cycle accumulator is cleared.
- Decode {red,yellow,green} each edge:
  - 100 = R, 110 = RY, 001 = G, 010 = Y.
  - 000, 011, 101, 111 are illegal.
- States:
  - SYNC (in_sync=0): holds the last legal sample. At the first edge where a legal sample differs from the held legal phase, go to TRACK with phase = new phase and cnt = 1. No report and no sequence check on this entry; cycle_started = (new phase == R).
  - TRACK (in_sync=1): at each edge, take one of the following actions.
    - Same phase, cnt < TIMEOUT: cnt <= cnt+1.
    - Same phase, cnt == TIMEOUT: set err_timeout, go to SYNC, no report.
    - Illegal combo: set err_illegal, go to SYNC.
    - Legal transition (R->RY, R->G, RY->G, G->Y, Y->R): dur_valid <= 1, dur_phase <= old phase, dur_cycles <= cnt, then cnt <= 1 and phase <= new phase.
    - Any other phase change: set err_seq, go to SYNC, no dur_valid.
- Also set err_illegal on an illegal combo while in SYNC; the held legal phase is unchanged.
- Cycle accumulator:
  - Adds each reported dur_cycles.
  - On a Y->R transition with cycle_started=1: cycle_valid <= 1, cycle_len <= accumulated total including the Y duration. The accumulator then restarts at 0 and cycle_started <= 1.
  - On a Y->R transition with cycle_started=0: no cycle_valid; the accumulator clears and cycle_started <= 1.
  - Going to SYNC clears the accumulator and cycle_started.
- Latency: the report is registered at the edge where the new pattern is first sampled and is visible the following cycle. dur_valid and cycle_valid are single-cycle pulses.
- cycle_len cannot overflow: maximum is 4*TIMEOUT < 2**(CNT_W+2).
- Error flags: stay set until clr_err. If clr_err and a new error occur in the same cycle, the new flag reads 1; other flags clear.
- phase holds its last value while in SYNC.
- rst_n low mid-phase: all outputs go to 0 immediately. After release, the block restarts in SYNC; the interrupted phase is never reported.

Test Plan:
1. Reset, then drive R15, RY6, G16, Y6 twice, then R.
   - Reports (phase,cycles): (1,6), (2,16), (3,6), (0,15), (1,6), (2,16), (3,6).
   - Only one cycle_valid, with cycle_len=43, on the second Y->R.
   - No errors; in_sync=1 from the first R->RY.
2. While tracking G, drive 101 for one cycle, then G.
   - err_illegal=1, in_sync=0, no dur_valid.
   - Pulse clr_err: err_illegal returns to 0.
3. While tracking, drive G8 then R.
   - err_seq=1, in_sync=0, no dur_valid for G.
   - Next legal change, R->RY, re-enters TRACK.
4. TIMEOUT=200: hold G for 200 samples, then Y.
   - dur_valid with (2,200), no error.
   - Repeat holding G for 201 samples: err_timeout=1, in_sync=0.
5. Assert rst_n low mid-G.
   - All outputs go to 0 asynchronously.
   - After release, the first G->Y enters TRACK with no report.
6. Force err_seq with clr_err=1 in the same cycle.
   - err_seq=1 afterwards.
   - The previously set err_illegal clears to 0.
